// File: rtl/ssd_scan_driver_if.sv
// Bundle between the datapath (master) and the seven-segment scan driver (slave).
// Carries load-side data/controls and the board-facing SSD pin outputs.
interface ssd_scan_driver_if #(
  parameter int N_DIGITS = 8,
  parameter int PWM_BITS = 4
);
  logic [4*N_DIGITS-1:0] Value;
  logic [N_DIGITS-1:0]   Dp_in;
  logic [N_DIGITS-1:0]   Digit_en;
  logic                  Load;
  logic                  Blank_lz;
  logic [PWM_BITS-1:0]   Brightness;
  logic [N_DIGITS-1:0]   An;
  logic [7:0]            Cathodes;
  logic                  Frame_done;

  modport master (
    output Value, Dp_in, Digit_en, Load, Blank_lz, Brightness,
    input  An, Cathodes, Frame_done
  );

  modport slave (
    input  Value, Dp_in, Digit_en, Load, Blank_lz, Brightness,
    output An, Cathodes, Frame_done
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// Multiplexed N-digit hex seven-segment driver: double-buffered loading,
// per-digit enable/decimal point, leading-zero blanking and PWM brightness.
module ssd_scan_driver #(
  parameter int N_DIGITS = 8,
  parameter int SCAN_DIV = 262144,
  parameter int PWM_BITS = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  ssd_scan_driver_if.slave bus
);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [PWM_BITS-1:0] BR_FULL  = '1;

  typedef struct packed {
    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   en;
  } frame_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  logic [PRE_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                slot_end;
  logic                frame_end;

  frame_t pend;
  frame_t act;
  logic   pend_vld;

  logic [N_DIGITS-1:0] lz_mask;
  logic                zero_run;
  logic [3:0]          nib_p0;
  logic                dark_p0;
  logic                lit_p0;
  logic [N_DIGITS-1:0] an_p0;
  logic [7:0]          cath_p0;
  logic                fd_p0;

  logic [N_DIGITS-1:0] an_p1;
  logic [7:0]          cath_p1;
  logic                fd_p1;

  assign slot_end  = (presc == PRE_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (slot_end) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Active only changes on a frame boundary; a Load landing on that same
  // edge stays pending so the frame being committed is never torn.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend     <= '0;
      act      <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (frame_end && pend_vld) begin
        act <= pend;
      end
      if (bus.Load) begin
        pend.value <= bus.Value;
        pend.dp    <= bus.Dp_in;
        pend.en    <= bus.Digit_en;
        pend_vld   <= 1'b1;
      end else if (frame_end) begin
        pend_vld   <= 1'b0;
      end
    end
  end

  // Stage p0: a digit is a leading zero if it and everything above it read
  // as zero, with disabled digits treated as zero. Digit 0 is always shown.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & ~(act.en[i] & (|act.value[4*i +: 4]));
      lz_mask[i] = zero_run && (i != 0);
    end
  end

  always_comb begin
    nib_p0  = act.value[{idx, 2'b00} +: 4];
    dark_p0 = ~act.en[idx] | (bus.Blank_lz & lz_mask[idx]);
    lit_p0  = ~dark_p0 & ((bus.Brightness == BR_FULL) | (pwm_cnt < bus.Brightness));
    an_p0   = '1;
    if (lit_p0) begin
      an_p0[idx] = 1'b0;
    end
    cath_p0 = dark_p0 ? 8'hFF : {seg_decode(nib_p0), ~act.dp[idx]};
    fd_p0   = (idx == '0) && (presc == '0);
  end

  // Stage p1: registered pin drivers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      an_p1   <= '1;
      cath_p1 <= 8'hFF;
      fd_p1   <= 1'b0;
    end else begin
      an_p1   <= an_p0;
      cath_p1 <= cath_p0;
      fd_p1   <= fd_p0;
    end
  end

  assign bus.An         = an_p1;
  assign bus.Cathodes   = cath_p1;
  assign bus.Frame_done = fd_p1;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver (4 digits, 4-cycle slots): directed literal
// scenarios plus randomized traffic checked against a cycle-indexed model.
module tb_ssd_scan_driver;
  localparam int N  = 4;
  localparam int S  = 4;
  localparam int NS = N * S;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ssd_scan_driver_if #(.N_DIGITS(N), .PWM_BITS(4)) bus ();

  ssd_scan_driver #(.N_DIGITS(N), .SCAN_DIV(S), .PWM_BITS(4)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned e;
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  en;
  } load_t;
  load_t lq[$];
  int unsigned t_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] tab [16];
    tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return tab[n];
  endfunction

  // Edge at which a Load sampled on edge e reaches the active buffer.
  function automatic int unsigned commit_edge(input int unsigned e);
    int unsigned b;
    b = (e / NS) * NS + NS - 1;
    if (b == e) b += NS;
    return b;
  endfunction

  // Model: edge te after reset release has idx=(te/S)%N, pwm=te%16; the
  // active buffer is the newest Load whose commit edge precedes te.
  always @(posedge clk) begin : cmp
    int unsigned te, idx, pwm;
    logic blz;
    logic [3:0] br, a_dp, a_en, an_e;
    logic [15:0] a_v, veff;
    logic [7:0] cath_e;
    logic dark, lz, found;
    load_t ent;
    if (!rst_n) begin
      t_m = 0;
      lq.delete();
      #1;
      chk("rst_an", 32'(bus.An), 32'hF);
      chk("rst_cath", 32'(bus.Cathodes), 32'hFF);
      chk("rst_fd", 32'(bus.Frame_done), 32'h0);
    end else begin
      te = t_m;
      t_m++;
      if (bus.Load) begin
        ent.e = te; ent.v = bus.Value; ent.dp = bus.Dp_in; ent.en = bus.Digit_en;
        lq.push_back(ent);
      end
      blz = bus.Blank_lz;
      br  = bus.Brightness;
      a_v = '0; a_dp = '0; a_en = '0; found = 1'b0;
      for (int i = lq.size() - 1; i >= 0; i--) begin
        if (!found && commit_edge(lq[i].e) < te) begin
          a_v = lq[i].v; a_dp = lq[i].dp; a_en = lq[i].en; found = 1'b1;
        end
      end
      veff = '0;
      for (int d = 0; d < N; d++) begin
        if (a_en[d]) veff[4*d +: 4] = a_v[4*d +: 4];
      end
      idx  = (te / S) % N;
      pwm  = te % 16;
      lz   = (idx != 0) && ((veff >> (4 * idx)) == 16'h0);
      dark = !a_en[idx] || (blz && lz);
      an_e = 4'hF;
      if (!dark && (br == 4'hF || pwm < int'(br))) an_e[idx] = 1'b0;
      cath_e = dark ? 8'hFF : {seg7(a_v[4*idx +: 4]), ~a_dp[idx]};
      #1;
      chk("model_an", 32'(bus.An), 32'(an_e));
      chk("model_cath", 32'(bus.Cathodes), 32'(cath_e));
      chk("model_fd", 32'(bus.Frame_done), 32'((te % NS) == 0));
    end
  end

  task automatic wait_frame();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.Frame_done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: Frame_done not seen within 40 cycles");
    end
  endtask

  task automatic sync_mid();
    wait_frame();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
    bus.Value = v; bus.Dp_in = dp; bus.Digit_en = en; bus.Load = 1'b1;
    @(negedge clk);
    bus.Load = 1'b0;
  endtask

  task automatic chk_frame(input string name, input logic [15:0] an4, input logic [31:0] cath4);
    int d;
    for (int k = 0; k < NS; k++) begin
      d = k / S;
      chk({name, "_an"}, 32'(bus.An), 32'(an4[4*d +: 4]));
      chk({name, "_cath"}, 32'(bus.Cathodes), 32'(cath4[8*d +: 8]));
      if (k != NS - 1) @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int fd_cnt, bad, lowc;
    bus.Load = 1'b0; bus.Value = '0; bus.Dp_in = '0; bus.Digit_en = '0;
    bus.Blank_lz = 1'b0; bus.Brightness = 4'hF;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    fd_cnt = 0; bad = 0;
    for (int k = 0; k < 3 * NS; k++) begin
      @(negedge clk);
      if (bus.Frame_done) fd_cnt++;
      if (bus.An !== 4'hF || bus.Cathodes !== 8'hFF) bad++;
    end
    chk("idle_dark_cycles", 32'(bad), 32'd0);
    chk("idle_fd_count", 32'(fd_cnt), 32'd3);

    sync_mid();
    do_load(16'h1A3F, 4'b0010, 4'hF);
    wait_frame();
    chk_frame("scan", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              {8'b10011111, 8'b00010001, 8'b00001100, 8'b01110001});

    sync_mid();
    do_load(16'h1234, 4'h0, 4'hF);
    @(negedge clk);
    do_load(16'h5678, 4'h0, 4'hF);
    wait_frame();
    chk_frame("tear", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              {8'h49, 8'h41, 8'h1F, 8'h01});

    bus.Blank_lz = 1'b1;
    sync_mid();
    do_load(16'h0030, 4'h0, 4'hF);
    wait_frame();
    chk_frame("lz", {4'hF, 4'hF, 4'b1101, 4'b1110},
              {8'hFF, 8'hFF, 8'b00001101, 8'b00000011});
    sync_mid();
    do_load(16'h0000, 4'h0, 4'hF);
    wait_frame();
    chk_frame("lz0", {4'hF, 4'hF, 4'hF, 4'b1110}, {8'hFF, 8'hFF, 8'hFF, 8'h03});

    bus.Blank_lz = 1'b0;
    sync_mid();
    do_load(16'hFFFF, 4'h0, 4'hF);
    bus.Brightness = 4'h4;
    wait_frame();
    lowc = 0;
    for (int k = 0; k < NS; k++) begin
      if (bus.An !== 4'hF) lowc++;
      if (k != NS - 1) @(negedge clk);
    end
    chk("pwm4_low_cycles", 32'(lowc), 32'd4);
    bus.Brightness = 4'h0;
    wait_frame();
    lowc = 0;
    for (int k = 0; k < NS; k++) begin
      if (bus.An !== 4'hF) lowc++;
      if (k != NS - 1) @(negedge clk);
    end
    chk("pwm0_low_cycles", 32'(lowc), 32'd0);

    bus.Brightness = 4'hF;
    wait_frame();
    repeat (9) @(negedge clk);
    chk("pre_rst_digit2", 32'(bus.An), 32'h0000000B);
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", 32'(bus.An), 32'hF);
    chk("async_rst_cath", 32'(bus.Cathodes), 32'hFF);
    chk("async_rst_fd", 32'(bus.Frame_done), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 2 * NS; k++) begin
      @(negedge clk);
      if (bus.An !== 4'hF || bus.Cathodes !== 8'hFF) bad++;
    end
    chk("post_rst_dark_cycles", 32'(bad), 32'd0);

    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      bus.Load     = ($urandom_range(0, 7) == 0);
      bus.Value    = 16'($urandom);
      bus.Dp_in    = 4'($urandom);
      bus.Digit_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 15) == 0) bus.Blank_lz = 1'($urandom);
      if ($urandom_range(0, 15) == 0) bus.Brightness = 4'($urandom);
      if ($urandom_range(0, 3) == 0) bus.Value = 16'($urandom_range(0, 255));
      if (k == 1500) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    bus.Load = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
